// File: rtl/latch_ctrl_seq.sv
// latch_ctrl_seq: command sequencer driving a three-latch bank with
// registered setup/pulse/hold timing at each pin's native polarity.
// Ports: clk, rst_n (sync, active-low), cmd_valid/cmd_ready/cmd_op/
// cmd_sel/cmd_data command handshake; D, ena1, ena2 (low), ena3,
// clr2, clr3 (low), pre3 (low) latch pins; done/err completion.
// Optional: define LATCH_CTRL_SEQ_SHADOW_EN to add exp_q[2:0], a
// registered model of the expected latch contents.
module latch_ctrl_seq #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_sel,
  input  logic       cmd_data,
  output logic       D,
  output logic       ena1,
  output logic       ena2,
  output logic       ena3,
  output logic       clr2,
  output logic       clr3,
  output logic       pre3,
`ifdef LATCH_CTRL_SEQ_SHADOW_EN
  output logic [2:0] exp_q,
`endif
  output logic       done,
  output logic       err
);

  if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_bad_setup
    $fatal(1, "SETUP_CYC out of range 1..255");
  end
  if (PULSE_CYC < 1 || PULSE_CYC > 255) begin : g_bad_pulse
    $fatal(1, "PULSE_CYC out of range 1..255");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
    $fatal(1, "HOLD_CYC out of range 1..255");
  end

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;
  localparam logic [1:0] OP_PRE = 2'd3;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] op_q;
  logic [1:0] sel_q;
  logic       legal;

  // Illegal: any op on sel 3, CLEAR of latch1 (no clear pin),
  // PRESET of anything but latch3.
  always_comb begin
    legal = 1'b1;
    unique case (1'b1)
      (cmd_sel == 2'd3):                       legal = 1'b0;
      (cmd_op == OP_CLR && cmd_sel == 2'd0):   legal = 1'b0;
      (cmd_op == OP_PRE && cmd_sel != 2'd2):   legal = 1'b0;
      default:                                 legal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= OP_NOP;
      sel_q     <= '0;
      D         <= 1'b0;
      ena1      <= 1'b0;
      ena2      <= 1'b1;
      ena3      <= 1'b0;
      clr2      <= 1'b0;
      clr3      <= 1'b1;
      pre3      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
`ifdef LATCH_CTRL_SEQ_SHADOW_EN
      exp_q     <= 3'b000;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            sel_q     <= cmd_sel;
            cmd_ready <= 1'b0;
            if (legal) begin
              state <= SETUP;
              cnt   <= SETUP_LD;
              if (cmd_op == OP_WR) D <= cmd_data;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state <= PULSE;
            cnt   <= PULSE_LD;
            case (op_q)
              OP_WR: begin
                case (sel_q)
                  2'd0:    ena1 <= 1'b1;
                  2'd1:    ena2 <= 1'b0;
                  default: ena3 <= 1'b1;
                endcase
              end
              OP_CLR: begin
                if (sel_q == 2'd1) clr2 <= 1'b1;
                else               clr3 <= 1'b0;
              end
              OP_PRE:  pre3 <= 1'b0;
              default: ;
            endcase
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PULSE: begin
          if (cnt == 8'd0) begin
            state <= HOLD;
            cnt   <= HOLD_LD;
            ena1  <= 1'b0;
            ena2  <= 1'b1;
            ena3  <= 1'b0;
            clr2  <= 1'b0;
            clr3  <= 1'b1;
            pre3  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state <= DONE;
            done  <= 1'b1;
`ifdef LATCH_CTRL_SEQ_SHADOW_EN
            case (op_q)
              OP_WR:   exp_q[sel_q] <= D;
              OP_CLR:  exp_q[sel_q] <= 1'b0;
              OP_PRE:  exp_q[2]     <= 1'b1;
              default: ;
            endcase
`endif
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_ctrl_seq.sv
// tb_latch_ctrl_seq: directed bench for latch_ctrl_seq (default timing)
// checking pin sequences, illegal commands, busy handshake, reset abort.
module tb_latch_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_sel = 2'd0;
  logic       cmd_data = 1'b0;
  logic       D, ena1, ena2, ena3, clr2, clr3, pre3, done, err;
`ifdef LATCH_CTRL_SEQ_SHADOW_EN
  logic [2:0] exp_q;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  latch_ctrl_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sel   (cmd_sel),
    .cmd_data  (cmd_data),
    .D         (D),
    .ena1      (ena1),
    .ena2      (ena2),
    .ena3      (ena3),
    .clr2      (clr2),
    .clr3      (clr3),
    .pre3      (pre3),
`ifdef LATCH_CTRL_SEQ_SHADOW_EN
    .exp_q     (exp_q),
`endif
    .done      (done),
    .err       (err)
  );

  // Vector layout: {D,ena1,ena2,ena3,clr2,clr3,pre3,done,err,rdy}
  localparam logic [9:0] M_ENA1 = 10'b0_1000_0000_0;
  localparam logic [9:0] M_ENA2 = 10'b0_0100_0000_0;
  localparam logic [9:0] M_ENA3 = 10'b0_0010_0000_0;
  localparam logic [9:0] M_CLR2 = 10'b0_0001_0000_0;
  localparam logic [9:0] M_CLR3 = 10'b0_0000_1000_0;
  localparam logic [9:0] M_PRE3 = 10'b0_0000_0100_0;
  localparam logic [9:0] M_DONE = 10'b0_0000_0010_0;
  localparam logic [9:0] M_ERR  = 10'b0_0000_0001_0;
  localparam logic [9:0] M_RDY  = 10'b0_0000_0000_1;

  function automatic logic [9:0] base(input logic d);
    return {d, 9'b0_1_0_0_1_1_0_0_0};
  endfunction

  function automatic logic [9:0] pins();
    return {D, ena1, ena2, ena3, clr2, clr3, pre3, done, err, cmd_ready};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sel,
                       input logic d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called in cycle 1 after accept; ends in cycle 6 (back in IDLE).
  task automatic expect_legal(input string tag, input logic d,
                              input logic [9:0] mask);
    chk({tag, "_c1"}, 32'(pins()), 32'(base(d)));
    tick();
    chk({tag, "_c2"}, 32'(pins()), 32'(base(d) ^ mask));
    tick();
    chk({tag, "_c3"}, 32'(pins()), 32'(base(d) ^ mask));
    tick();
    chk({tag, "_c4"}, 32'(pins()), 32'(base(d)));
    tick();
    chk({tag, "_c5"}, 32'(pins()), 32'(base(d) | M_DONE));
    tick();
    chk({tag, "_c6"}, 32'(pins()), 32'(base(d) | M_RDY));
  endtask

  task automatic expect_illegal(input string tag, input logic d);
    chk({tag, "_c1"}, 32'(pins()), 32'(base(d) | M_DONE | M_ERR));
    tick();
    chk({tag, "_c2"}, 32'(pins()), 32'(base(d) | M_RDY));
  endtask

  // At most one control pin away from its idle level in any cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_ctl", 32'(int'(ena1) + int'(!ena2) + int'(ena3) +
                         int'(clr2) + int'(!clr3) + int'(!pre3) <= 1),
          32'd1);
    end
  end

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_hold", 32'(pins()), 32'(base(1'b0) | M_RDY));
    rst_n = 1'b1;
    tick();
    chk("rst_idle", 32'(pins()), 32'(base(1'b0) | M_RDY));

    issue(2'd1, 2'd1, 1'b1);
    expect_legal("wr_l2", 1'b1, M_ENA2);
`ifdef LATCH_CTRL_SEQ_SHADOW_EN
    chk("shadow_wr", 32'(exp_q), 32'h2);
`endif

    issue(2'd2, 2'd2, 1'b0);
    expect_legal("clr_l3", 1'b1, M_CLR3);
    issue(2'd3, 2'd2, 1'b0);
    expect_legal("pre_l3", 1'b1, M_PRE3);
`ifdef LATCH_CTRL_SEQ_SHADOW_EN
    chk("shadow_pre", 32'(exp_q), 32'h6);
`endif

    issue(2'd2, 2'd0, 1'b0);
    expect_illegal("ill_clr0", 1'b1);
    issue(2'd3, 2'd1, 1'b0);
    expect_illegal("ill_pre1", 1'b1);
    issue(2'd1, 2'd3, 1'b0);
    expect_illegal("ill_sel3", 1'b1);
`ifdef LATCH_CTRL_SEQ_SHADOW_EN
    chk("shadow_ill", 32'(exp_q), 32'h6);
`endif

    issue(2'd0, 2'd0, 1'b0);
    expect_legal("nop", 1'b1, 10'd0);
    issue(2'd2, 2'd1, 1'b0);
    expect_legal("clr_l2", 1'b1, M_CLR2);
    issue(2'd1, 2'd0, 1'b0);
    expect_legal("wr_l1", 1'b0, M_ENA1);

    // Valid held high with a new command while busy.
    issue(2'd1, 2'd0, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_sel   = 2'd1;
    cmd_data  = 1'b0;
    expect_legal("busy1", 1'b1, M_ENA1);
    tick();
    cmd_valid = 1'b0;
    expect_legal("busy2", 1'b0, M_ENA2);

    // Reset while ena3 pulses; no done afterwards.
    issue(2'd1, 2'd2, 1'b1);
    tick();
    chk("mid_pulse", 32'(pins()), 32'(base(1'b1) ^ M_ENA3));
    rst_n = 1'b0;
    tick();
    chk("mid_rst", 32'(pins()), 32'(base(1'b0) | M_RDY));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst", 32'(pins()), 32'(base(1'b0) | M_RDY));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
